// File: rtl/cpu_ctrl_fsm_pkg.sv
// Shared definitions for the RISC CPU control path: instruction fields,
// opcodes, sequencer state encodings and the registered control bundle.
package cpu_defs;

  localparam int INSTR_W = 16;
  localparam int OPC_W   = 3;
  localparam int ADDR_W  = 13;

  localparam logic [OPC_W-1:0] OP_HLT  = 3'b000;
  localparam logic [OPC_W-1:0] OP_SKZ  = 3'b001;
  localparam logic [OPC_W-1:0] OP_ADD  = 3'b010;
  localparam logic [OPC_W-1:0] OP_ANDD = 3'b011;
  localparam logic [OPC_W-1:0] OP_XORR = 3'b100;
  localparam logic [OPC_W-1:0] OP_LDA  = 3'b101;
  localparam logic [OPC_W-1:0] OP_STO  = 3'b110;
  localparam logic [OPC_W-1:0] OP_JMP  = 3'b111;

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4,
    S5 = 3'd5,
    S6 = 3'd6,
    S7 = 3'd7
  } state_t;

  typedef struct packed {
    logic inc_pc;
    logic load_pc;
    logic load_ir;
    logic load_acc;
    logic rd;
    logic wr;
    logic datactl_ena;
  } ctrl_t;

  function automatic logic is_alu_op(input logic [OPC_W-1:0] op);
    return (op == OP_ADD) || (op == OP_ANDD) || (op == OP_XORR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/cpu_ctrl_fsm.sv
// Fetch/execute sequencer: one state per clock, every strobe a flop loaded
// from the decode of the state being entered.
module cpu_ctrl_fsm
  import cpu_defs::*;
#(
  parameter bit HALT_STICKY = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero,
  output logic             inc_pc,
  output logic             load_pc,
  output logic             load_ir,
  output logic             load_acc,
  output logic             rd,
  output logic             wr,
  output logic             datactl_ena,
  output logic             halt,
  output logic [2:0]       state
);

  state_t state_q, state_d;
  ctrl_t  ctl_q, ctl_d;

  logic op_alu, op_sto, op_jmp, op_skz, op_hlt;

  assign op_alu = is_alu_op(opcode);
  assign op_sto = (opcode == OP_STO);
  assign op_jmp = (opcode == OP_JMP);
  assign op_skz = (opcode == OP_SKZ);
  assign op_hlt = (opcode == OP_HLT);

  // S0 has an idle and a fetch phase: an enabled idle S0 re-enters S0 with the
  // first byte read active, and only that fetch S0 (rd set) advances to S1.
  always_comb begin
    state_d = state_q;
    ctl_d   = '0;
    unique case (state_q)
      S0: begin
        if (ctl_q.rd) begin
          state_d       = S1;
          ctl_d.rd      = 1'b1;
          ctl_d.load_ir = 1'b1;
          ctl_d.inc_pc  = 1'b1;
        end else if (ena) begin
          state_d       = S0;
          ctl_d.rd      = 1'b1;
          ctl_d.load_ir = 1'b1;
        end else begin
          state_d = S0;
        end
      end
      S1: begin
        state_d       = S2;
        ctl_d.rd      = 1'b1;
        ctl_d.load_ir = 1'b1;
      end
      S2: begin
        state_d       = S3;
        ctl_d.rd      = 1'b1;
        ctl_d.load_ir = 1'b1;
        ctl_d.inc_pc  = 1'b1;
      end
      S3: begin
        state_d = S4;
      end
      S4: begin
        if (HALT_STICKY && op_hlt) begin
          state_d = S4;
        end else begin
          state_d           = S5;
          ctl_d.rd          = op_alu;
          ctl_d.datactl_ena = op_sto;
          ctl_d.load_pc     = op_jmp;
          ctl_d.inc_pc      = op_skz && zero;
        end
      end
      S5: begin
        state_d           = S6;
        ctl_d.rd          = op_alu;
        ctl_d.load_acc    = op_alu;
        ctl_d.datactl_ena = op_sto;
        ctl_d.wr          = op_sto;
        ctl_d.load_pc     = op_jmp;
        ctl_d.inc_pc      = op_jmp;
      end
      S6: begin
        state_d           = S7;
        ctl_d.datactl_ena = op_sto;
        ctl_d.load_pc     = op_jmp;
        ctl_d.inc_pc      = op_skz && zero;
      end
      S7: begin
        state_d = S0;
      end
      default: begin
        state_d = S0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S0;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      ctl_q   <= ctl_d;
    end
  end

  assign inc_pc      = ctl_q.inc_pc;
  assign load_pc     = ctl_q.load_pc;
  assign load_ir     = ctl_q.load_ir;
  assign load_acc    = ctl_q.load_acc;
  assign rd          = ctl_q.rd;
  assign wr          = ctl_q.wr;
  assign datactl_ena = ctl_q.datactl_ena;
  assign state       = state_q;

  // The opcode only becomes valid once S4 is entered, so halt is decoded from
  // the registered state rather than pre-registered; it drives no clock.
  assign halt = (state_q == S4) && op_hlt;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Randomized bench for cpu_ctrl_fsm: sticky and non-sticky instances checked
// per cycle against a rule-based waveform model and a PC edge model.
module tb_cpu_ctrl_fsm;
  import cpu_defs::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [2:0] opcode;
  logic       zero;

  logic a_inc_pc, a_load_pc, a_load_ir, a_load_acc, a_rd, a_wr, a_dct, a_halt;
  logic b_inc_pc, b_load_pc, b_load_ir, b_load_acc, b_rd, b_wr, b_dct, b_halt;
  logic [2:0] a_state, b_state;

  cpu_ctrl_fsm #(.HALT_STICKY(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .ena(ena), .opcode(opcode), .zero(zero),
    .inc_pc(a_inc_pc), .load_pc(a_load_pc), .load_ir(a_load_ir),
    .load_acc(a_load_acc), .rd(a_rd), .wr(a_wr), .datactl_ena(a_dct),
    .halt(a_halt), .state(a_state)
  );

  cpu_ctrl_fsm #(.HALT_STICKY(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .ena(ena), .opcode(opcode), .zero(zero),
    .inc_pc(b_inc_pc), .load_pc(b_load_pc), .load_ir(b_load_ir),
    .load_acc(b_load_acc), .rd(b_rd), .wr(b_wr), .datactl_ena(b_dct),
    .halt(b_halt), .state(b_state)
  );

  always #5 clk = ~clk;

  logic [7:0] ctl_a, ctl_b;
  assign ctl_a = {a_inc_pc, a_load_pc, a_load_ir, a_load_acc, a_rd, a_wr, a_dct, a_halt};
  assign ctl_b = {b_inc_pc, b_load_pc, b_load_ir, b_load_acc, b_rd, b_wr, b_dct, b_halt};

  // Program counter as the datapath sees it: clocked by inc_pc edges.
  logic [12:0] ir_addr = '0;
  logic [12:0] pc_a = '0;
  logic [12:0] pc_b = '0;
  always @(posedge a_inc_pc) pc_a <= a_load_pc ? ir_addr : pc_a + 13'd1;
  always @(posedge b_inc_pc) pc_b <= b_load_pc ? ir_addr : pc_b + 13'd1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Expected strobes at cycle k (0..7) of an instruction, packed as
  // {inc_pc, load_pc, load_ir, load_acc, rd, wr, datactl_ena, halt}.
  function automatic logic [7:0] model_ctl(input int op, input bit z, input int k);
    bit alu, sto, jmp, skz, hlt;
    bit inc, lpc, lir, lacc, r, w, dct, h;
    alu  = (op >= 2) && (op <= 5);
    sto  = (op == 6);
    jmp  = (op == 7);
    skz  = (op == 1);
    hlt  = (op == 0);
    inc  = (k == 1) || (k == 3) || (jmp && k == 6) || (skz && z && (k == 5 || k == 7));
    lpc  = jmp && (k >= 5);
    lir  = (k <= 3);
    lacc = alu && (k == 6);
    r    = (k <= 3) || (alu && (k == 5 || k == 6));
    w    = sto && (k == 6);
    dct  = sto && (k >= 5);
    h    = hlt && (k == 4);
    return {inc, lpc, lir, lacc, r, w, dct, h};
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_state_a"}, 32'(a_state), 32'd0);
    chk({tag, "_ctl_a"},   32'(ctl_a),   32'd0);
    chk({tag, "_state_b"}, 32'(b_state), 32'd0);
    chk({tag, "_ctl_b"},   32'(ctl_b),   32'd0);
  endtask

  // Entered and left at a negedge with both instances in idle S0.
  task automatic run_instr(input int op, input bit z, input logic [12:0] addr,
                           input bit drop_ena);
    logic [12:0] sa, sb, ea, eb;
    ir_addr = addr;
    ena     = 1'b1;
    opcode  = 3'($urandom);
    zero    = 1'($urandom);
    sa      = pc_a;
    sb      = pc_b;
    @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("state_a op%0d k%0d", op, k), 32'(a_state), 32'(k));
      chk($sformatf("ctl_a op%0d z%0d k%0d", op, z, k), 32'(ctl_a), 32'(model_ctl(op, z, k)));
      chk($sformatf("state_b op%0d k%0d", op, k), 32'(b_state), 32'(k));
      chk($sformatf("ctl_b op%0d z%0d k%0d", op, z, k), 32'(ctl_b), 32'(model_ctl(op, z, k)));
      if (k < 3) begin
        opcode = 3'($urandom);
        zero   = 1'($urandom);
      end
      if (k == 0 && drop_ena) ena = 1'b0;
      if (k == 3) begin
        opcode = 3'(op);
        zero   = z;
      end
      if (k == 7) begin
        ea = (op == 7) ? addr : sa + ((op == 1 && z) ? 13'd4 : 13'd2);
        eb = (op == 7) ? addr : sb + ((op == 1 && z) ? 13'd4 : 13'd2);
        chk($sformatf("pc_a op%0d z%0d", op, z), 32'(pc_a), 32'(ea));
        chk($sformatf("pc_b op%0d z%0d", op, z), 32'(pc_b), 32'(eb));
        ena = 1'b0;
      end
    end
    @(negedge clk);
    check_idle($sformatf("post_op%0d", op));
  endtask

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b0;
    opcode = '0;
    zero   = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("in_reset");
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_idle($sformatf("idle%0d", i));
    end

    run_instr(5, 1'b0, 13'h0123, 1'b0);
    run_instr(6, 1'b1, 13'h0456, 1'b1);
    run_instr(7, 1'b0, 13'h1A2B, 1'b0);
    run_instr(1, 1'b1, 13'h0000, 1'b0);
    run_instr(1, 1'b0, 13'h0000, 1'b1);
    run_instr(2, 1'b1, 13'h1FFF, 1'b0);
    for (int i = 0; i < 30; i++)
      run_instr(int'($urandom_range(1, 7)), 1'($urandom), 13'($urandom), 1'($urandom));

    // Reset arriving in S6 of a store must drop wr without waiting for a clock.
    ena = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk($sformatf("sto_rst_state k%0d", k), 32'(a_state), 32'(k));
      if (k == 3) opcode = OP_STO;
    end
    ena = 1'b0;
    chk("sto_wr_before_rst", 32'(a_wr), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("sto_wr_async_a", 32'(a_wr), 32'd0);
    chk("sto_wr_async_b", 32'(b_wr), 32'd0);
    chk("sto_ctl_async_a", 32'(ctl_a), 32'd0);
    chk("sto_state_async_a", 32'(a_state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("after_sto_rst");

    // HLT: sticky instance parks in S4, non-sticky pulses halt and finishes as a NOP.
    ena = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("hlt_state_a k%0d", k), 32'(a_state), 32'(k));
      chk($sformatf("hlt_ctl_a k%0d", k), 32'(ctl_a), 32'(model_ctl(0, 1'b0, k)));
      chk($sformatf("hlt_ctl_b k%0d", k), 32'(ctl_b), 32'(model_ctl(0, 1'b0, k)));
      if (k == 0) ena = 1'b0;
      if (k == 3) opcode = OP_HLT;
    end
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      chk($sformatf("hlt_stick_state c%0d", c), 32'(a_state), 32'd4);
      chk($sformatf("hlt_stick_ctl c%0d", c), 32'(ctl_a), 32'h01);
      if (c < 3) begin
        chk($sformatf("hlt_ns_state c%0d", c), 32'(b_state), 32'(c + 5));
        chk($sformatf("hlt_ns_ctl c%0d", c), 32'(ctl_b), 32'(model_ctl(0, 1'b0, c + 5)));
      end else begin
        chk($sformatf("hlt_ns_idle_state c%0d", c), 32'(b_state), 32'd0);
        chk($sformatf("hlt_ns_idle_ctl c%0d", c), 32'(ctl_b), 32'd0);
      end
    end
    rst_n = 1'b0;
    #1;
    chk("hlt_rst_state", 32'(a_state), 32'd0);
    chk("hlt_rst_halt", 32'(a_halt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    opcode = OP_LDA;
    @(negedge clk);
    check_idle("after_hlt_rst");
    run_instr(4, 1'b1, 13'h0ABC, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
